// File: rtl/full_xor_nk.sv
// N-share Boolean unmasker: log-depth pairwise refresh, share register, then an
// (optionally pipelined) XOR-reduction tree with valid/ready flow control and flush.
package full_xor_nk_pkg;

    function automatic int num_layers(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Refresh pairs contained in layers 0 .. upto-1.
    function automatic int pair_count(input int n, input int upto);
        int c = 0;
        for (int l = 0; l < upto; l++) begin
            for (int i = 0; i < n; i++) begin
                if ((((i >> l) & 1) == 0) && ((i + (1 << l)) < n)) c++;
            end
        end
        return c;
    endfunction

    // Random-word index of the layer-l pair whose lower member is lo.
    function automatic int pair_index(input int n, input int l, input int lo);
        int c = pair_count(n, l);
        for (int i = 0; i < lo; i++) begin
            if ((((i >> l) & 1) == 0) && ((i + (1 << l)) < n)) c++;
        end
        return c;
    endfunction

    function automatic int level_width(input int n, input int t);
        int w = n;
        for (int k = 0; k < t; k++) w = (w + 1) / 2;
        return w;
    endfunction

endpackage

module full_xor_nk
    import full_xor_nk_pkg::*;
#(
    parameter int  K_WIDTH   = 32,
    parameter int  N_SHARES  = 8,
    parameter int  TREE_PIPE = 1,
    localparam int LAYERS    = num_layers(N_SHARES),
    localparam int RANDNUM   = pair_count(N_SHARES, LAYERS),
    localparam int RND_WORDS = (RANDNUM > 0) ? RANDNUM : 1,
    localparam int LAT       = 1 + TREE_PIPE * LAYERS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [K_WIDTH*RND_WORDS-1:0]   rnd,
    input  logic [K_WIDTH*N_SHARES-1:0]    i_x,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [K_WIDTH-1:0]             o_z
);

    localparam int NSTG = (TREE_PIPE != 0) ? LAYERS + 1 : 1;

    logic [K_WIDTH-1:0] ref_s [LAYERS+1][N_SHARES];
    logic [K_WIDTH-1:0] lvl_s [LAYERS+1][N_SHARES];
    logic [K_WIDTH-1:0] s0_q  [N_SHARES];
    logic [NSTG-1:0]    vld_q;
    logic [NSTG-1:0]    vld_d;
    logic [NSTG-1:0]    shift_s;
    logic               stall_s;
    logic               adv_s;
    logic               acc_s;

    assign o_valid = vld_q[NSTG-1];
    assign stall_s = o_valid & ~o_ready;
    assign adv_s   = ~stall_s;
    assign i_ready = adv_s & ~flush;
    assign acc_s   = i_valid & i_ready;

    if (RANDNUM == 0) begin : g_no_rnd
        logic unused_rnd_s;
        assign unused_rnd_s = ^rnd;
    end

    // Refresh only ever XORs a random word into a share; shares stay apart until s0_q.
    for (genvar j = 0; j < N_SHARES; j++) begin : g_in
        assign ref_s[0][j] = i_x[j*K_WIDTH +: K_WIDTH];
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_ref
        for (genvar j = 0; j < N_SHARES; j++) begin : g_sh
            localparam int P = j ^ (1 << l);
            if (P < N_SHARES) begin : g_pair
                localparam int RI = pair_index(N_SHARES, l, (j < P) ? j : P);
                assign ref_s[l+1][j] = ref_s[l][j] ^ rnd[RI*K_WIDTH +: K_WIDTH];
            end else begin : g_pass
                assign ref_s[l+1][j] = ref_s[l][j];
            end
        end
    end

    // Stage-0 share register, loaded only on an accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_SHARES; j++) s0_q[j] <= '0;
        end else if (acc_s) begin
            for (int j = 0; j < N_SHARES; j++) s0_q[j] <= ref_s[LAYERS][j];
        end
    end

    for (genvar j = 0; j < N_SHARES; j++) begin : g_l0
        assign lvl_s[0][j] = s0_q[j];
    end

    for (genvar t = 1; t <= LAYERS; t++) begin : g_lvl
        localparam int WIN  = level_width(N_SHARES, t - 1);
        localparam int WOUT = level_width(N_SHARES, t);
        logic [K_WIDTH-1:0] xr_s [N_SHARES];

        for (genvar j = 0; j < N_SHARES; j++) begin : g_w
            if (j >= WOUT) begin : g_idle
                assign xr_s[j] = '0;
            end else if (2*j + 1 < WIN) begin : g_xor
                assign xr_s[j] = lvl_s[t-1][2*j] ^ lvl_s[t-1][2*j+1];
            end else begin : g_odd
                assign xr_s[j] = lvl_s[t-1][2*j];
            end
        end

        if (TREE_PIPE != 0) begin : g_reg
            logic [K_WIDTH-1:0] lvl_q [N_SHARES];

            // Tree-level register; moves with the rest of the pipeline.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < N_SHARES; j++) lvl_q[j] <= '0;
                end else if (adv_s) begin
                    for (int j = 0; j < N_SHARES; j++) lvl_q[j] <= xr_s[j];
                end
            end

            for (genvar j = 0; j < N_SHARES; j++) begin : g_o
                assign lvl_s[t][j] = lvl_q[j];
            end
        end else begin : g_comb
            for (genvar j = 0; j < N_SHARES; j++) begin : g_o
                assign lvl_s[t][j] = xr_s[j];
            end
        end
    end

    assign o_z = lvl_s[LAYERS][0];

    if (NSTG > 1) begin : g_shift
        assign shift_s = {vld_q[NSTG-2:0], acc_s};
    end else begin : g_single
        assign shift_s = acc_s;
    end

    // Valid-bit next state: flush beats both advance and stall.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (adv_s) begin
            vld_d = shift_s;
        end else begin
            vld_d = vld_q;
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

endmodule

// File: doc/full_xor_nk.md
Name: full_xor_nk

Overview:
- Parametrised successor of the fixed 8-share full-XOR unmasker.
- Takes N_SHARES Boolean shares of a K_WIDTH word and applies a log-depth pairwise refresh network using fresh randomness.
- Registers the refreshed shares, then XOR-reduces them to the unmasked value through an optionally pipelined tree.
- Adds valid/ready backpressure, a synchronous flush, and support for any N_SHARES ≥ 1, not only powers of two. Sits at the tail of the B2A / masked-arithmetic datapath.

Parameters:
- K_WIDTH, 32, bits per share.
- N_SHARES, 8, number of input shares, ≥1.
- TREE_PIPE, 1, 1 = register after every XOR-tree level; 0 = combinational tree after the share register.
- LAYERS, derived = clog2(N_SHARES) (0 when N_SHARES=1), number of refresh layers and tree levels.
- RANDNUM, derived = total refresh pairs.
  - Layer l pairs share i with share i+2^l, for every i with bit l of i = 0 and i+2^l < N_SHARES.
  - Each pair consumes one K_WIDTH word. Words are assigned in layer order, ascending i.
  - N_SHARES=8 gives 12.
- LAT, derived = 1 + TREE_PIPE*LAYERS, input-accept to output-valid latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all valid bits; data registers are not cleared.
- i_valid  in  1  input word valid.
- i_ready  out  1  block can accept this cycle.
- rnd  in  K_WIDTH*max(RANDNUM,1)  fresh randomness, sampled with i_x on accept. Ignored when RANDNUM=0.
- i_x  in  K_WIDTH*N_SHARES  input shares, share j at [j*K_WIDTH +: K_WIDTH].
- o_valid  out  1  o_z valid.
- o_ready  in  1  downstream accepts.
- o_z  out  K_WIDTH  unmasked value = XOR of all shares.

Behaviour:
- Reset (async, rst=1): all stage valid bits → 0, all data registers → 0. o_valid=0, o_z=0, i_ready=1 after reset.
- Refresh network (combinational, before stage 0):
  - Layer l XORs the pair's random word into both members of each pair.
  - Shares without a partner in a layer pass unchanged.
  - Randomness cancels pairwise, so the XOR of all shares is invariant.
- Stage 0 captures the refreshed shares on accept (i_valid & i_ready).
- No two distinct shares may be XORed together before the stage-0 register. This is a security requirement and must not be optimised across.
- Tree level t XORs adjacent pairs of level t-1 words. An odd leftover word passes through unchanged. Level LAYERS produces o_z.
- TREE_PIPE=1: a register plus valid bit after each level, so LAT=1+LAYERS (8 shares → 4). TREE_PIPE=0: o_z is the combinational tree of stage 0, LAT=1.
- Pipeline flow:
  - stall = o_valid & ~o_ready.
  - Every stage advances when ~stall. On stall, all stages hold.
  - i_ready = ~stall. There are no bubble-collapsing or skid buffers.
  - Throughput is one word per cycle when o_ready is held at 1.
- Output holds o_z and o_valid stable while stalled.
- flush=1 clears all valid bits at the next edge, and no input is accepted that cycle (i_ready=0).
- flush has priority over accept and over simultaneous output handshake. A word handshaken in the same cycle as flush is considered delivered.
- Reset mid-operation discards in-flight words. No output after deassertion until a new accept plus LAT cycles.
- Degenerate case N_SHARES=1: no refresh and no tree; o_z = registered i_x; LAT=1.
- Degenerate case N_SHARES=2: one refresh word, one tree level.
- Data width is K_WIDTH throughout. There is no carry, purely bitwise XOR.

Test Plan:
- N=8, TREE_PIPE=1, o_ready=1: shares 0x11111111,0x22222222,0x44444444,0x88888888,0,0,0,0x0000000F, random rnd → o_z=0xFFFFFFF0, o_valid exactly 4 cycles after accept. Repeat with 100 random rnd values: o_z unchanged.
- Back-to-back: 16 consecutive accepts with o_ready=1 → 16 consecutive o_valid cycles, in order, each equal to the XOR of its input shares.
- Backpressure: o_ready=0 for 5 cycles while o_valid=1 → o_z and o_valid stable, i_ready=0. On release, the stream resumes with no loss or duplication.
- Flush: 3 words in flight, flush pulsed 1 cycle → o_valid=0 next cycle and those words never appear. A word accepted after the flush emerges LAT cycles later.
- Async reset asserted between clock edges with the pipeline full → o_valid and o_z drop to 0 immediately. i_ready=1 after release.
- Sweep N_SHARES ∈ {1,2,3,5,8} × TREE_PIPE ∈ {0,1} with random shares and rnd:
  - o_z always equals the XOR of the shares.
  - Latency equals LAT.
  - RANDNUM equals 0, 1, 2, 5, 12 for N = 1, 2, 3, 5, 8.
